// File: rtl/async_reset_sync_vec.sv
// Vector shift pipeline with async active-high reset, settle flag
// and a one-cycle change pulse on the output.
//
// Ports:
//   clk     - clock, rising edge
//   rst     - async active-high reset
//   en      - shift enable
//   d       - data into stage 0
//   q       - last stage, forced to INIT while rst
//   settled - DEPTH enabled edges seen since reset
//   chg     - q took a new value on last edge while settled

module async_reset_sync_vec #(
  parameter int               WIDTH = 1,
  parameter int               DEPTH = 3,
  parameter logic [WIDTH-1:0] INIT  = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             settled,
  output logic             chg
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [WIDTH-1:0] s [DEPTH];
  logic [CW-1:0]    cnt;
  logic             chg_r;
  logic             full;
  logic [WIDTH-1:0] shift_in;

  assign full = (cnt == FULL);

  // value about to land in the last stage
  if (DEPTH == 1) begin : g_d1
    assign shift_in = d;
  end else begin : g_dn
    assign shift_in = s[DEPTH-2];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        s[i] <= INIT;
      end
      cnt   <= '0;
      chg_r <= 1'b0;
    end else begin
      // fill transitions never pulse: full is judged pre-edge
      chg_r <= en && full &&
               (shift_in != s[DEPTH-1]);
      if (en) begin
        s[0] <= d;
        for (int i = 1; i < DEPTH; i++) begin
          s[i] <= s[i-1];
        end
        if (!full) begin
          cnt <= cnt + CW'(1);
        end
      end
    end
  end

  // rst gates outputs directly so they reach reset
  // values without waiting for the flops
  assign q       = rst ? INIT : s[DEPTH-1];
  assign settled = full && !rst;
  assign chg     = chg_r && !rst;

endmodule

// File: tb/tb_async_reset_sync_vec.sv
// Scoreboard bench for async_reset_sync_vec.
// Three instances: W8/D3/A5, W1/D1/1, W4/D8/0.

module tb_async_reset_sync_vec;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, en_a;
  logic [7:0] d_a, q_a;
  logic       set_a, chg_a;

  logic       rst_b, en_b;
  logic       d_b, q_b;
  logic       set_b, chg_b;

  logic       rst_c, en_c;
  logic [3:0] d_c, q_c;
  logic       set_c, chg_c;

  async_reset_sync_vec #(
    .WIDTH(8), .DEPTH(3), .INIT(8'hA5)
  ) u_a (
    .clk(clk), .rst(rst_a), .en(en_a), .d(d_a),
    .q(q_a), .settled(set_a), .chg(chg_a)
  );

  async_reset_sync_vec #(
    .WIDTH(1), .DEPTH(1), .INIT(1'b1)
  ) u_b (
    .clk(clk), .rst(rst_b), .en(en_b), .d(d_b),
    .q(q_b), .settled(set_b), .chg(chg_b)
  );

  async_reset_sync_vec #(
    .WIDTH(4), .DEPTH(8), .INIT(4'h0)
  ) u_c (
    .clk(clk), .rst(rst_c), .en(en_c), .d(d_c),
    .q(q_c), .settled(set_c), .chg(chg_c)
  );

  typedef struct packed {
    logic [1:0] inst;
    logic [7:0] q;
    logic       s;
    logic       c;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  event  sample_ev;
  int    total = 0;
  int    bad   = 0;

  // monitor: pops after each edge or async sample request
  initial begin
    exp_t       e;
    string      nm;
    logic [7:0] aq;
    logic       as, ac;
    forever begin
      @(posedge clk or sample_ev);
      #1;
      while (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        case (e.inst)
          2'd0: begin aq = q_a; as = set_a; ac = chg_a; end
          2'd1: begin
            aq = {7'b0, q_b}; as = set_b; ac = chg_b;
          end
          default: begin
            aq = {4'b0, q_c}; as = set_c; ac = chg_c;
          end
        endcase
        total++;
        if (aq !== e.q || as !== e.s || ac !== e.c) begin
          bad++;
          $display("FAIL %s: got q=%h settled=%b chg=%b, want q=%h settled=%b chg=%b",
                   nm, aq, as, ac, e.q, e.s, e.c);
        end
      end
    end
  end

  task automatic push(input int inst, input logic [7:0] eq,
                      input logic es, input logic ec,
                      input string nm);
    exp_t e;
    e.inst = 2'(inst);
    e.q    = eq;
    e.s    = es;
    e.c    = ec;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  // drive one edge's inputs, expect state after that edge
  task automatic step(input int inst, input logic e,
                      input logic [7:0] dv, input logic [7:0] eq,
                      input logic es, input logic ec,
                      input string nm);
    @(negedge clk);
    case (inst)
      0:       begin en_a = e; d_a = dv; end
      1:       begin en_b = e; d_b = dv[0]; end
      default: begin en_c = e; d_c = dv[3:0]; end
    endcase
    push(inst, eq, es, ec, nm);
  endtask

  // check without a clock edge
  task automatic now_chk(input int inst, input logic [7:0] eq,
                         input logic es, input logic ec,
                         input string nm);
    push(inst, eq, es, ec, nm);
    ->sample_ev;
    #2;
  endtask

  initial begin
    int k;
    rst_a = 1'b1; en_a = 1'b0; d_a = '0;
    rst_b = 1'b1; en_b = 1'b0; d_b = '0;
    rst_c = 1'b1; en_c = 1'b0; d_c = '0;
    #1;
    now_chk(0, 8'hA5, 1'b0, 1'b0, "rst_a");
    now_chk(1, 8'h01, 1'b0, 1'b0, "rst_b");
    now_chk(2, 8'h00, 1'b0, 1'b0, "rst_c");

    // fill and latency
    @(negedge clk); rst_a = 1'b0;
    step(0, 1, 8'h01, 8'hA5, 0, 0, "fill1");
    step(0, 1, 8'h02, 8'hA5, 0, 0, "fill2");
    step(0, 1, 8'h03, 8'h01, 1, 0, "fill3");
    step(0, 1, 8'h04, 8'h02, 1, 1, "post4");
    // change detection
    step(0, 1, 8'h55, 8'h03, 1, 1, "d55_1");
    step(0, 1, 8'h55, 8'h04, 1, 1, "d55_2");
    step(0, 1, 8'h55, 8'h55, 1, 1, "d55_3");
    step(0, 1, 8'hAA, 8'h55, 1, 0, "dAA_1");
    step(0, 1, 8'hAA, 8'h55, 1, 0, "dAA_2");
    step(0, 1, 8'hAA, 8'hAA, 1, 1, "dAA_3");
    step(0, 1, 8'hAA, 8'hAA, 1, 0, "dAA_4");
    step(0, 1, 8'hAA, 8'hAA, 1, 0, "dAA_5");
    // enable gating
    step(0, 1, 8'h10, 8'hAA, 1, 0, "en1_10");
    step(0, 0, 8'h20, 8'hAA, 1, 0, "en0_20");
    step(0, 0, 8'h30, 8'hAA, 1, 0, "en0_30");
    step(0, 1, 8'h40, 8'hAA, 1, 0, "en1_40");
    step(0, 1, 8'h40, 8'h10, 1, 1, "out_10");
    step(0, 1, 8'h40, 8'h40, 1, 1, "out_40");
    step(0, 1, 8'h40, 8'h40, 1, 0, "hold40");
    // async reset mid-pulse
    step(0, 1, 8'hAA, 8'h40, 1, 0, "pre_aa1");
    step(0, 1, 8'hAA, 8'h40, 1, 0, "pre_aa2");
    step(0, 1, 8'hAA, 8'hAA, 1, 1, "pre_aa3");
    @(negedge clk); rst_a = 1'b1;
    now_chk(0, 8'hA5, 0, 0, "async_rst");
    step(0, 1, 8'h77, 8'hA5, 0, 0, "rst_hold");
    @(negedge clk); rst_a = 1'b0; en_a = 1'b0;
    step(0, 1, 8'h11, 8'hA5, 0, 0, "refill1");
    step(0, 1, 8'h22, 8'hA5, 0, 0, "refill2");
    step(0, 1, 8'h33, 8'h11, 1, 0, "refill3");
    step(0, 0, 8'h00, 8'h11, 1, 0, "a_idle");

    // DEPTH=1
    @(negedge clk); rst_b = 1'b0;
    step(1, 1, 8'h00, 8'h00, 1, 0, "d1_e1");
    step(1, 1, 8'h01, 8'h01, 1, 1, "d1_e2");
    step(1, 1, 8'h01, 8'h01, 1, 0, "d1_e3");
    step(1, 0, 8'h00, 8'h01, 1, 0, "d1_en0");

    // DEPTH=8 saturation
    @(negedge clk); rst_c = 1'b0;
    for (k = 1; k <= 300; k++) begin
      step(2, 1, 8'(k & 15),
           (k >= 8) ? 8'((k - 7) & 15) : 8'h00,
           k >= 8, k >= 9, "sat");
    end

    k = 0;
    while (exp_q.size() > 0 && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (exp_q.size() > 0) begin
      bad++;
      $display("FAIL drain: got %0d pending, want 0",
               exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/async_reset_sync_vec.md
ASYNC_RESET_SYNC_VEC -- requirements
Module: async_reset_sync_vec

Interface
REQ-001 SHALL have parameter WIDTH, default 1, data width in bits, legal range 1..64.
REQ-002 SHALL have parameter DEPTH, default 3, number of shift stages, legal range 1..8.
REQ-003 SHALL have parameter INIT, default all-zeros, WIDTH-bit value loaded into every stage on reset.
REQ-004 SHALL have port clk  input  1  clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port en  input  1  shift enable; when low, all stages, counter and chg hold/clear per Function.
REQ-007 SHALL have port d  input  WIDTH  data into stage 0.
REQ-008 SHALL have port q  output  WIDTH  last-stage data, forced to INIT while rst is high.
REQ-009 SHALL have port settled  output  1  high once DEPTH enabled edges have occurred since reset release.
REQ-010 SHALL have port chg  output  1  one-cycle pulse: q took a new, different value on the last edge while settled.

Function
REQ-011 SHALL hold DEPTH WIDTH-bit stages s[0..DEPTH-1]; on a rising clk edge with en=1 and rst=0: s[0]<=d, s[i]<=s[i-1] for i=1..DEPTH-1.
REQ-012 SHALL hold all stages unchanged on a rising clk edge with en=0.
REQ-013 SHALL drive q = INIT combinationally whenever rst=1, else q = s[DEPTH-1]; no clock needed for q to reach INIT.
REQ-014 SHALL give latency d->q of exactly DEPTH enabled rising edges (DEPTH=1: q equals d sampled on the previous enabled edge).
REQ-015 SHALL keep a settle counter cnt, width ceil(log2(DEPTH+1)), incremented by 1 on each enabled edge while cnt<DEPTH, saturating at DEPTH, never wrapping.
REQ-016 SHALL drive settled = (cnt==DEPTH) AND NOT rst, combinationally from the registered counter.
REQ-017 SHALL, on each rising edge, load chg register with: en AND (cnt==DEPTH before the edge) AND (value being shifted into s[DEPTH-1] != current s[DEPTH-1]); value shifted in is s[DEPTH-2], or d when DEPTH=1.
REQ-018 SHALL drive chg output = chg register AND NOT rst; chg is high in the same cycle q first shows the new value.
REQ-019 SHALL NOT assert chg for the fill transitions occurring before settled, i.e. during the first DEPTH enabled edges after reset.
REQ-020 SHALL clear chg register to 0 on any rising edge with en=0.
REQ-021 SHALL hold cnt unchanged when en=0; en=0 cycles do not count toward settling.
REQ-022 SHALL treat d as sampled only on enabled edges; d changes between edges have no effect.
REQ-023 SHALL have no combinational path from d or en to any output.

Reset
REQ-024 SHALL, on rst rising, immediately and asynchronously set all s[i]=INIT, cnt=0, chg register=0, independent of clk and en.
REQ-025 SHALL hold that state for the whole time rst=1, ignoring clk edges and en.
REQ-026 SHALL give reset-value outputs q=INIT, settled=0, chg=0 whenever rst=1, including reset asserted mid-shift or mid-pulse.
REQ-027 SHALL resume shifting on the first enabled rising edge after rst falls; deassertion synchronization is the integrator's responsibility.
REQ-028 SHALL NOT rely on initial blocks for function; state before the first reset is unspecified, and the bench applies reset at time 0.

Verification
REQ-029 SHALL verify fill/latency with WIDTH=8, DEPTH=3, INIT=8'hA5: reset, then en=1 with d=01,02,03,04 on consecutive edges -> q stays A5 for 2 edges, q=01 after edge 3, settled rises after edge 3, chg=0 throughout the fill.
REQ-030 SHALL verify change detection with the same config once settled: d=55 held 3 edges then d=AA -> chg pulses exactly once, in the cycle q becomes AA; d held at AA -> chg stays 0.
REQ-031 SHALL verify enable gating: settled, en toggled 1,0,0,1 with d=10,20,30,40 -> only 10 and 40 enter the pipe; chg=0 on every en=0 edge; cnt unchanged.
REQ-032 SHALL verify async reset mid-operation: rst pulsed high between clk edges while chg=1 and q=AA -> q=A5, settled=0, chg=0 before the next clk edge; after release settled needs 3 fresh enabled edges.
REQ-033 SHALL verify DEPTH=1, WIDTH=1, INIT=1: reset, d=0 on edge 1 -> q=0 and settled=1 after edge 1, chg=0; d=1 on edge 2 -> q=1, chg=1 for one cycle.
REQ-034 SHALL verify counter saturation with DEPTH=8: 300 enabled edges after reset -> settled stays 1 from edge 8 onward with no drop (no wrap).
